// File: rtl/led_mode_scheduler.sv
// ============================================================================
// Module : led_mode_scheduler
// Debounced two-key mode sequencer (off / manual step / auto-cycle) feeding
// the LED driver selector with a mode code and a captured switch pattern.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module led_mode_scheduler #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int DWELL_CYCLES    = 250_000_000,
  parameter int NUM_MODES       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_next_n,
  input  logic       key_auto_n,
  input  logic [7:0] sw_led,
  output logic [3:0] mode_select,
  output logic [7:0] led_select,
  output logic       auto_on,
  output logic       mode_strobe
);

  localparam int c_db_w = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int c_dw_w = $clog2(DWELL_CYCLES + 1);

  localparam logic [c_db_w-1:0] c_db_last  = c_db_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_dw_w-1:0] c_dw_last  = c_dw_w'(DWELL_CYCLES - 1);
  localparam logic [3:0]        c_mode_max = 4'(NUM_MODES);

  localparam logic [1:0] c_st_off    = 2'd0;
  localparam logic [1:0] c_st_manual = 2'd1;
  localparam logic [1:0] c_st_auto   = 2'd2;

  // Bit 0 = next key, bit 1 = auto key.
  logic [1:0] w_key_raw;
  logic [1:0] w_press;

  assign w_key_raw = {key_auto_n, key_next_n};

  generate
    for (genvar g = 0; g < 2; g++) begin : g_key
      logic              r_sync1;
      logic              r_sync2;
      logic              r_stable;
      logic              r_press;
      logic [c_db_w-1:0] r_db_cnt;

      // Released (1) is the idle level, so reset never fakes a press.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sync1  <= 1'b1;
          r_sync2  <= 1'b1;
          r_stable <= 1'b1;
          r_press  <= 1'b0;
          r_db_cnt <= '0;
        end else begin
          r_sync1 <= w_key_raw[g];
          r_sync2 <= r_sync1;
          r_press <= 1'b0;
          if (r_sync2 == r_stable) begin
            r_db_cnt <= '0;
          end else if (r_db_cnt == c_db_last) begin
            r_stable <= r_sync2;
            r_press  <= ~r_sync2;
            r_db_cnt <= '0;
          end else begin
            r_db_cnt <= r_db_cnt + c_db_w'(1);
          end
        end
      end

      assign w_press[g] = r_press;
    end
  endgenerate

  logic              w_next_p;
  logic              w_auto_p;
  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [3:0]        r_mode;
  logic [3:0]        w_mode_nxt;
  logic [3:0]        w_mode_adv;
  logic [c_dw_w-1:0] r_dwell;
  logic [c_dw_w-1:0] w_dwell_nxt;
  logic [7:0]        r_led;
  logic              r_auto;
  logic              r_strobe;
  logic              w_mode_chg;

  assign w_next_p   = w_press[0];
  assign w_auto_p   = w_press[1];
  assign w_mode_adv = (r_mode >= c_mode_max) ? 4'd1 : r_mode + 4'd1;
  assign w_mode_chg = (w_mode_nxt != r_mode);

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_st_off;
      r_mode   <= 4'd0;
      r_dwell  <= '0;
      r_led    <= 8'h00;
      r_auto   <= 1'b0;
      r_strobe <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_mode   <= w_mode_nxt;
      r_dwell  <= w_dwell_nxt;
      r_auto   <= (w_state_nxt == c_st_auto);
      r_strobe <= w_mode_chg;
      if (w_mode_chg) begin
        r_led <= sw_led;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_off: begin
        if (w_auto_p)      w_state_nxt = c_st_auto;
        else if (w_next_p) w_state_nxt = c_st_manual;
      end
      c_st_manual: begin
        if (w_auto_p) w_state_nxt = c_st_auto;
      end
      c_st_auto: begin
        if (w_auto_p) w_state_nxt = c_st_manual;
      end
      default: w_state_nxt = c_st_off;
    endcase
  end

  // Auto press has priority; a next press on the dwell terminal advances once.
  always_comb begin
    w_mode_nxt  = r_mode;
    w_dwell_nxt = '0;
    case (r_state)
      c_st_off: begin
        if (w_auto_p || w_next_p) w_mode_nxt = 4'd1;
      end
      c_st_manual: begin
        if (!w_auto_p && w_next_p) w_mode_nxt = w_mode_adv;
      end
      c_st_auto: begin
        if (!w_auto_p) begin
          if (w_next_p || (r_dwell == c_dw_last)) begin
            w_mode_nxt = w_mode_adv;
          end else begin
            w_dwell_nxt = r_dwell + c_dw_w'(1);
          end
        end
      end
      default: begin
        w_mode_nxt  = 4'd0;
      end
    endcase
  end

  assign mode_select = r_mode;
  assign led_select  = r_led;
  assign auto_on     = r_auto;
  assign mode_strobe = r_strobe;

endmodule

`default_nettype wire

// File: tb/tb_led_mode_scheduler.sv
// ============================================================================
// Module : tb_led_mode_scheduler
// Self-checking bench for led_mode_scheduler against an event-level reference.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_led_mode_scheduler;

  localparam int DB = 4;
  localparam int DW = 16;
  localparam int NM = 4;

  localparam int M_OFF  = 0;
  localparam int M_MAN  = 1;
  localparam int M_AUTO = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_next_n = 1'b1;
  logic       key_auto_n = 1'b1;
  logic [7:0] sw_led = 8'h00;
  logic [3:0] mode_select;
  logic [7:0] led_select;
  logic       auto_on;
  logic       mode_strobe;

  int checks = 0;
  int errors = 0;
  int strobe_seen = 0;

  // Reference model state.
  bit       m_hist [2][16];
  bit       m_stable [2];
  bit       m_pulse [2];
  int       m_state;
  int       m_mode;
  int       m_dwell;
  bit [7:0] m_led;
  bit       m_strobe;

  led_mode_scheduler #(
    .DEBOUNCE_CYCLES (DB),
    .DWELL_CYCLES    (DW),
    .NUM_MODES       (NM)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_next_n  (key_next_n),
    .key_auto_n  (key_auto_n),
    .sw_led      (sw_led),
    .mode_select (mode_select),
    .led_select  (led_select),
    .auto_on     (auto_on),
    .mode_strobe (mode_strobe)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) m_hist[k][i] = 1'b1;
      m_stable[k] = 1'b1;
      m_pulse[k]  = 1'b0;
    end
    m_state  = M_OFF;
    m_mode   = 0;
    m_dwell  = 0;
    m_led    = 8'h00;
    m_strobe = 1'b0;
  endfunction

  // One clock edge: apply last cycle's press pulses, then look at the key history.
  function automatic void model_edge();
    int prev;
    bit ap, np, all_diff;
    bit raw [2];
    ap = m_pulse[1];
    np = m_pulse[0];
    prev = m_mode;
    case (m_state)
      M_OFF: begin
        if (ap)      begin m_state = M_AUTO; m_mode = 1; m_dwell = 0; end
        else if (np) begin m_state = M_MAN;  m_mode = 1; end
      end
      M_MAN: begin
        if (ap)      begin m_state = M_AUTO; m_dwell = 0; end
        else if (np) m_mode = (m_mode % NM) + 1;
      end
      default: begin
        if (ap) m_state = M_MAN;
        else if (np || m_dwell == DW - 1) begin m_mode = (m_mode % NM) + 1; m_dwell = 0; end
        else m_dwell = m_dwell + 1;
      end
    endcase
    m_strobe = (m_mode != prev);
    if (m_strobe) m_led = sw_led;

    raw[0] = key_next_n;
    raw[1] = key_auto_n;
    for (int k = 0; k < 2; k++) begin
      for (int i = 15; i > 0; i--) m_hist[k][i] = m_hist[k][i-1];
      m_hist[k][0] = raw[k];
      m_pulse[k] = 1'b0;
      // Synced level lags raw by two edges; needs DB consecutive differing samples.
      all_diff = 1'b1;
      for (int i = 2; i < DB + 2; i++) if (m_hist[k][i] == m_stable[k]) all_diff = 1'b0;
      if (all_diff) begin
        m_stable[k] = m_hist[k][2];
        m_pulse[k]  = (m_hist[k][2] == 1'b0);
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    @(negedge clk);
    if (mode_strobe) strobe_seen++;
  endtask

  task automatic press_key(input bit auto_key, input int hold, input int rel);
    if (auto_key) key_auto_n = 1'b0; else key_next_n = 1'b0;
    repeat (hold) tick();
    key_auto_n = 1'b1;
    key_next_n = 1'b1;
    repeat (rel) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sw_led = 8'hA5;
    model_reset();
    tick();
    tick();
    checks++; if (mode_select !== 4'd0) begin errors++; $display("FAIL reset_mode got %0d want 0", mode_select); end
    checks++; if (led_select !== 8'h00) begin errors++; $display("FAIL reset_led got %h want 00", led_select); end
    checks++; if (auto_on !== 1'b0) begin errors++; $display("FAIL reset_auto got %b want 0", auto_on); end
    checks++; if (mode_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b want 0", mode_strobe); end
  endtask

  task automatic test_first_press();
    rst_n = 1'b1;
    key_next_n = 1'b0;
    strobe_seen = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 6) begin
        checks++; if (mode_select !== 4'd0) begin errors++; $display("FAIL first_early got %0d want 0", mode_select); end
      end
      if (i == 7) begin
        checks++; if (mode_select !== 4'd1) begin errors++; $display("FAIL first_latency got %0d want 1", mode_select); end
        checks++; if (mode_strobe !== 1'b1) begin errors++; $display("FAIL first_strobe got %b want 1", mode_strobe); end
      end
    end
    checks++; if (led_select !== 8'hA5) begin errors++; $display("FAIL first_led got %h want a5", led_select); end
    checks++; if (auto_on !== 1'b0) begin errors++; $display("FAIL first_auto got %b want 0", auto_on); end
    checks++; if (strobe_seen != 1) begin errors++; $display("FAIL first_strobe_count got %0d want 1", strobe_seen); end
    key_next_n = 1'b1;
    sw_led = 8'h3C;
    repeat (10) tick();
  endtask

  task automatic test_bounce();
    strobe_seen = 0;
    for (int i = 0; i < 12; i++) begin
      key_next_n = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
    end
    checks++; if (mode_select !== 4'd1) begin errors++; $display("FAIL bounce_nostep got %0d want 1", mode_select); end
    key_next_n = 1'b0;
    repeat (10) tick();
    checks++; if (mode_select !== 4'd2) begin errors++; $display("FAIL bounce_step got %0d want 2", mode_select); end
    checks++; if (led_select !== 8'h3C) begin errors++; $display("FAIL bounce_led got %h want 3c", led_select); end
    repeat (50) tick();
    checks++; if (mode_select !== 4'd2) begin errors++; $display("FAIL hold_mode got %0d want 2", mode_select); end
    checks++; if (strobe_seen != 1) begin errors++; $display("FAIL hold_strobe_count got %0d want 1", strobe_seen); end
    key_next_n = 1'b1;
    repeat (10) tick();
  endtask

  task automatic test_wrap();
    press_key(1'b0, 10, 10);
    press_key(1'b0, 10, 10);
    checks++; if (mode_select !== 4'd4) begin errors++; $display("FAIL wrap_pre got %0d want 4", mode_select); end
    strobe_seen = 0;
    sw_led = 8'h96;
    press_key(1'b0, 10, 10);
    checks++; if (mode_select !== 4'd1) begin errors++; $display("FAIL wrap_mode got %0d want 1", mode_select); end
    checks++; if (strobe_seen != 1) begin errors++; $display("FAIL wrap_strobe_count got %0d want 1", strobe_seen); end
    checks++; if (led_select !== 8'h96) begin errors++; $display("FAIL wrap_led got %h want 96", led_select); end
    press_key(1'b0, 10, 10);
  endtask

  task automatic test_auto();
    strobe_seen = 0;
    key_auto_n = 1'b0;
    repeat (7) tick();
    checks++; if (auto_on !== 1'b1) begin errors++; $display("FAIL auto_enter got %b want 1", auto_on); end
    checks++; if (mode_select !== 4'd2) begin errors++; $display("FAIL auto_keep got %0d want 2", mode_select); end
    for (int c = 1; c <= 48; c++) begin
      if (c == 3) key_auto_n = 1'b1;
      tick();
      checks++; if (mode_select !== 4'(m_mode)) begin errors++; $display("FAIL auto_model c=%0d got %0d want %0d", c, mode_select, m_mode); end
      if (c == 15) begin
        checks++; if (mode_select !== 4'd2) begin errors++; $display("FAIL auto_15 got %0d want 2", mode_select); end
      end
      if (c == 16) begin
        checks++; if (mode_select !== 4'd3 || mode_strobe !== 1'b1) begin errors++; $display("FAIL auto_16 got %0d/%b want 3/1", mode_select, mode_strobe); end
      end
      if (c == 32) begin
        checks++; if (mode_select !== 4'd4) begin errors++; $display("FAIL auto_32 got %0d want 4", mode_select); end
      end
      if (c == 48) begin
        checks++; if (mode_select !== 4'd1) begin errors++; $display("FAIL auto_48 got %0d want 1", mode_select); end
      end
    end
    checks++; if (strobe_seen != 3) begin errors++; $display("FAIL auto_strobe_count got %0d want 3", strobe_seen); end
    key_auto_n = 1'b0;
    repeat (7) tick();
    checks++; if (auto_on !== 1'b0) begin errors++; $display("FAIL auto_exit got %b want 0", auto_on); end
    key_auto_n = 1'b1;
    repeat (20) tick();
    checks++; if (mode_select !== 4'd1) begin errors++; $display("FAIL auto_held got %0d want 1", mode_select); end
  endtask

  task automatic test_both();
    press_key(1'b0, 10, 10);
    strobe_seen = 0;
    key_next_n = 1'b0;
    key_auto_n = 1'b0;
    repeat (7) tick();
    checks++; if (auto_on !== 1'b1) begin errors++; $display("FAIL both_auto got %b want 1", auto_on); end
    checks++; if (mode_select !== 4'd2) begin errors++; $display("FAIL both_mode got %0d want 2", mode_select); end
    checks++; if (strobe_seen != 0) begin errors++; $display("FAIL both_strobe_count got %0d want 0", strobe_seen); end
    for (int c = 1; c <= 9; c++) begin
      if (c == 3) begin key_next_n = 1'b1; key_auto_n = 1'b1; end
      tick();
    end
    key_next_n = 1'b0;
    repeat (7) tick();
    checks++; if (mode_select !== 4'd3) begin errors++; $display("FAIL term_mode got %0d want 3", mode_select); end
    checks++; if (strobe_seen != 1) begin errors++; $display("FAIL term_strobe_count got %0d want 1", strobe_seen); end
    for (int c = 1; c <= 15; c++) begin
      if (c == 3) key_next_n = 1'b1;
      tick();
    end
    checks++; if (mode_select !== 4'd3) begin errors++; $display("FAIL term_hold got %0d want 3", mode_select); end
    tick();
    checks++; if (mode_select !== 4'd4) begin errors++; $display("FAIL term_next got %0d want 4", mode_select); end
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    while (!(m_state == M_AUTO && m_mode == 3 && m_dwell == 9) && n < 200) begin
      tick();
      n++;
    end
    checks++; if (n >= 200) begin errors++; $display("FAIL mid_search got %0d cycles want <200", n); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mode_select !== 4'd0) begin errors++; $display("FAIL mid_mode got %0d want 0", mode_select); end
    checks++; if (led_select !== 8'h00) begin errors++; $display("FAIL mid_led got %h want 00", led_select); end
    checks++; if (auto_on !== 1'b0) begin errors++; $display("FAIL mid_auto got %b want 0", auto_on); end
    checks++; if (mode_strobe !== 1'b0) begin errors++; $display("FAIL mid_strobe got %b want 0", mode_strobe); end
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    checks++; if (mode_select !== 4'd0 || auto_on !== 1'b0) begin errors++; $display("FAIL mid_off got %0d/%b want 0/0", mode_select, auto_on); end
    key_auto_n = 1'b0;
    repeat (7) tick();
    checks++; if (mode_select !== 4'd1 || auto_on !== 1'b1) begin errors++; $display("FAIL mid_reenter got %0d/%b want 1/1", mode_select, auto_on); end
    for (int c = 1; c <= 16; c++) begin
      if (c == 3) key_auto_n = 1'b1;
      tick();
      if (c == 15) begin
        checks++; if (mode_select !== 4'd1) begin errors++; $display("FAIL mid_dwell15 got %0d want 1", mode_select); end
      end
    end
    checks++; if (mode_select !== 4'd2) begin errors++; $display("FAIL mid_dwell16 got %0d want 2", mode_select); end
  endtask

  task automatic test_random();
    int rem [2];
    rem[0] = 0;
    rem[1] = 0;
    for (int c = 0; c < 800; c++) begin
      if (rem[0] == 0) begin key_next_n = ~key_next_n; rem[0] = $urandom_range(1, 14); end
      if (rem[1] == 0) begin key_auto_n = ~key_auto_n; rem[1] = $urandom_range(1, 30); end
      rem[0]--;
      rem[1]--;
      if ($urandom_range(0, 7) == 0) sw_led = 8'($urandom);
      tick();
      checks++;
      if (mode_select !== 4'(m_mode) || led_select !== m_led || auto_on !== (m_state == M_AUTO) ||
          mode_strobe !== m_strobe) begin
        errors++;
        $display("FAIL random c=%0d got mode=%0d led=%h auto=%b stb=%b want mode=%0d led=%h auto=%b stb=%b",
                 c, mode_select, led_select, auto_on, mode_strobe, m_mode, m_led, m_state == M_AUTO, m_strobe);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_press();
    test_bounce();
    test_wrap();
    test_auto();
    test_both();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
